// File: rtl/seq_decoder_pkg.sv
// Shared encodings for the sequenced decoder: request modes and FSM states.
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/seq_decoder_pattern.sv
// Combinational pattern generator: one-hot (1<<idx) or thermometer (bits idx..0 set).
module seq_decoder_pattern #(
  parameter int N    = 3,
  parameter int OUTS = 1 << N
) (
  input  logic [N-1:0]    idx_i,
  input  logic            therm_i,
  output logic [OUTS-1:0] pat_o
);

  always_comb begin
    pat_o = '0;
    for (int unsigned i = 0; i < OUTS; i++) begin
      pat_o[i] = therm_i ? (i <= 32'(idx_i)) : (i == 32'(idx_i));
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Sequenced decoder: one-hot / thermometer / clear on request, or a dwell-timed
// scan walking a single set bit across the output, wrapping at the top.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int OUTS    = 1 << N,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_sel,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUTS-1:0]    out,
  output logic               out_valid,
  output logic               scan_wrap
);

  state_e             state_q;
  logic [N-1:0]       pos_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [OUTS-1:0]    out_q;
  logic               out_valid_q;
  logic               scan_wrap_q;

  logic               accept;
  logic               adv;
  logic [N-1:0]       pos_d;
  logic [N-1:0]       pat_idx;
  logic               pat_therm;
  logic [OUTS-1:0]    pat;

  assign in_ready  = en && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign scan_wrap = scan_wrap_q;

  // The single pattern instance serves the request path in IDLE and the
  // next scan position in SCAN; position arithmetic wraps in N bits.
  always_comb begin
    adv       = (cnt_q == dwell_q);
    pos_d     = adv ? pos_q + N'(1) : pos_q;
    pat_idx   = (state_q == SCAN) ? pos_d : in_sel;
    pat_therm = (state_q == IDLE) && (mode_e'(mode) == MODE_THERM);
  end

  seq_decoder_pattern #(.N(N), .OUTS(OUTS)) u_pattern (
    .idx_i   (pat_idx),
    .therm_i (pat_therm),
    .pat_o   (pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      cnt_q       <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          scan_wrap_q <= 1'b0;
          if (accept) begin
            unique case (mode_e'(mode))
              MODE_ONEHOT, MODE_THERM: begin
                out_q       <= pat;
                out_valid_q <= 1'b1;
              end
              MODE_SCAN: begin
                state_q     <= SCAN;
                pos_q       <= in_sel;
                dwell_q     <= dwell;
                cnt_q       <= '0;
                out_q       <= pat;
                out_valid_q <= 1'b1;
              end
              MODE_CLEAR: begin
                out_q       <= '0;
                out_valid_q <= 1'b0;
              end
            endcase
          end
        end
        SCAN: begin
          if (!en) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
          end else if (adv) begin
            cnt_q       <= '0;
            pos_q       <= pos_d;
            out_q       <= pat;
            scan_wrap_q <= &pos_q;
          end else begin
            cnt_q       <= cnt_q + DWELL_W'(1);
            scan_wrap_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: scan positions are derived from elapsed cycles since
// scan start, compared every cycle, plus literal checks from directed scenarios.
module tb_seq_decoder;
  localparam int N       = 3;
  localparam int OUTS    = 8;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_sel;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [OUTS-1:0]    out;
  logic               out_valid;
  logic               scan_wrap;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  seq_decoder #(.N(N), .OUTS(OUTS), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .mode      (mode),
    .dwell     (dwell),
    .out       (out),
    .out_valid (out_valid),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  // Model: scan position = (start + elapsed / (dwell+1)) mod OUTS.
  bit       m_scan  = 1'b0;
  int       m_start = 0;
  int       m_dwell = 0;
  int       m_k     = 0;
  logic [7:0] m_out = '0;
  bit       m_valid = 1'b0;
  bit       m_wrap  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 0; m_start = 0; m_dwell = 0; m_k = 0;
      m_out = '0; m_valid = 0; m_wrap = 0;
    end else if (!m_scan) begin
      m_wrap = 0;
      if (en && in_valid) begin
        case (mode)
          2'b00: begin m_out = 8'(1 << int'(in_sel)); m_valid = 1; end
          2'b01: begin m_out = 8'((2 << int'(in_sel)) - 1); m_valid = 1; end
          2'b10: begin
            m_scan = 1; m_start = int'(in_sel); m_dwell = int'(dwell); m_k = 0;
            m_out = 8'(1 << int'(in_sel)); m_valid = 1;
          end
          default: begin m_out = '0; m_valid = 0; end
        endcase
      end
    end else if (!en) begin
      m_scan = 0; m_out = '0; m_valid = 0; m_wrap = 0;
    end else begin
      int p;
      m_k++;
      p = (m_start + m_k / (m_dwell + 1)) % OUTS;
      m_out  = 8'(1 << p);
      m_wrap = (m_k % (m_dwell + 1) == 0) && (p == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (out !== m_out) begin
        fails++;
        $display("FAIL model_out t=%0t got=%h exp=%h", $time, out, m_out);
      end
      tests++;
      if (out_valid !== m_valid) begin
        fails++;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
      end
      tests++;
      if (scan_wrap !== m_wrap) begin
        fails++;
        $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, scan_wrap, m_wrap);
      end
      tests++;
      if (in_ready !== (en && !m_scan)) begin
        fails++;
        $display("FAIL model_ready t=%0t got=%b exp=%b", $time, in_ready, en && !m_scan);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [N-1:0] s, input logic [1:0] m, input logic [DWELL_W-1:0] d);
    in_sel = s; mode = m; dwell = d; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  logic [7:0] s3_exp [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
  logic       s3_wrp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] s4_exp [7] = '{8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h10};

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_sel = '0; mode = '0; dwell = '0;
    cyc();
    chk_en = 1'b1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; en = 1'b1;
    #1 check("ready_after_reset", 32'(in_ready), 32'h1);

    req(3'd5, 2'b00, '0);
    check("s1_out", 32'(out), 32'h20);
    check("s1_valid", 32'(out_valid), 32'h1);
    check("s1_ready", 32'(in_ready), 32'h1);

    req(3'd0, 2'b01, '0);
    check("s2_therm0", 32'(out), 32'h01);
    req(3'd7, 2'b01, '0);
    check("s2_therm7", 32'(out), 32'hFF);
    req(3'd3, 2'b01, '0);
    check("s2_therm3", 32'(out), 32'h0F);

    cyc(3);
    check("idle_hold", 32'(out), 32'h0F);
    en = 1'b0; in_valid = 1'b1; in_sel = 3'd1; mode = 2'b00;
    cyc(2);
    in_valid = 1'b0;
    check("en0_hold", 32'(out), 32'h0F);
    check("en0_ready", 32'(in_ready), 32'h0);
    en = 1'b1;

    req(3'd4, 2'b11, '0);
    check("clear_out", 32'(out), 32'h0);
    check("clear_valid", 32'(out_valid), 32'h0);

    req(3'd6, 2'b10, 8'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s3_out%0d", i), 32'(out), 32'(s3_exp[i]));
      check($sformatf("s3_wrap%0d", i), 32'(scan_wrap), 32'(s3_wrp[i]));
      check($sformatf("s3_ready%0d", i), 32'(in_ready), 32'h0);
      cyc();
    end
    cyc(5);
    en = 1'b0;
    cyc();
    check("s5_out", 32'(out), 32'h0);
    check("s5_valid", 32'(out_valid), 32'h0);
    en = 1'b1;
    #1 check("s5_ready", 32'(in_ready), 32'h1);

    req(3'd2, 2'b10, 8'd2);
    in_sel = 3'd7; dwell = 8'd0; mode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("s4_out%0d", i), 32'(out), 32'(s4_exp[i]));
      cyc();
    end
    cyc(20);

    en = 1'b0;
    cyc();
    en = 1'b1;
    req(3'd0, 2'b10, 8'd0);
    check("start0_out", 32'(out), 32'h01);
    check("start0_nowrap", 32'(scan_wrap), 32'h0);
    cyc(9);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("s6_async_out", 32'(out), 32'h0);
    check("s6_async_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    req(3'd1, 2'b00, '0);
    check("s6_after", 32'(out), 32'h02);
    check("s6_after_valid", 32'(out_valid), 32'h1);
    cyc(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
